fetch_unit: RTL

- Parametrised instruction-fetch front end. Replaces the fixed PC register, +2 adder and instruction-memory lookup that feed the IF/ID buffer.
- Issues in-order requests to an instruction memory whose latency is variable (1 cycle or more), through a req/gnt handshake.
- Buffers returned instructions, each with its PC, in a DEPTH-entry prefetch queue.
- Presents the queue head to IF/ID through a valid/ready handshake.
- Supports branch redirect: flushes the queue and silently drops every response still in flight.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 66 ++++++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types, default widths and sizing helpers for the instruction-fetch front end.
package fetch_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int INSTR_W_DEF  = 16;
    localparam int DEPTH_DEF    = 4;
    localparam int RESET_PC_DEF = 0;
    localparam int PC_STEP_DEF  = 2;

    // One prefetch-queue entry at the default widths: instruction plus the PC it was fetched from.
    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0]  pc;
    } fetch_entry_t;

    // Width of counters that must represent 0..DEPTH inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO. Pointers carry an extra wrap bit so full and empty
// are distinguishable without a separate counter; flush empties it in one cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                DATA_W     = 24,
    parameter int                DEPTH      = 4,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic [DATA_W-1:0]        head
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic              w_empty;
    logic              w_full;
    logic              w_pop_ok;
    logic              w_push_ok;

    assign count     = r_wr_ptr - r_rd_ptr;
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop_ok  = pop & ~w_empty;
    // A push into a full queue is only safe when the head leaves in the same cycle.
    assign w_push_ok = push & (~w_full | w_pop_ok);
    assign head      = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Storage: cleared to the reset entry so the head reads a defined value after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_DATA;
            end
        end else if (w_push_ok && !flush) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

    // Read/write pointers; flush discards every stored entry.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues in-order requests to a variable-latency
// instruction memory, buffers responses with their PCs and hands the head to IF/ID.
// A redirect flushes the queue and marks every in-flight response for discard.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int RESET_PC = RESET_PC_DEF,
    parameter int PC_STEP  = PC_STEP_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rsp_valid,
    input  logic [INSTR_W-1:0] mem_rsp_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc_plus
);

    localparam int                        CNT_W     = cnt_w(DEPTH);
    localparam int                        ENTRY_W   = INSTR_W + ADDR_W;
    localparam logic [ADDR_W-1:0]         RST_PC    = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0]         STEP      = ADDR_W'(PC_STEP);
    localparam logic [CNT_W-1:0]          CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]            DEPTH_EXT = (CNT_W + 1)'(DEPTH);
    localparam logic [ENTRY_W-1:0]        RST_ENTRY = {{INSTR_W{1'b0}}, RST_PC};

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_rsp_pc;
    logic [CNT_W-1:0]   r_outstanding;
    logic [CNT_W-1:0]   r_discard;

    logic [ADDR_W-1:0]  w_fetch_pc_nxt;
    logic [ADDR_W-1:0]  w_rsp_pc_nxt;
    logic [CNT_W-1:0]   w_outstanding_nxt;
    logic [CNT_W-1:0]   w_discard_nxt;

    logic [CNT_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_head;
    logic [CNT_W:0]     w_occupancy;
    logic               w_credit;
    logic               w_issue;
    logic               w_rsp_taken;
    logic               w_push;
    logic               w_pop;

    // Slots already claimed: queued entries plus live (not-to-be-discarded) requests.
    assign w_occupancy = {1'b0, w_count} + {1'b0, r_outstanding} - {1'b0, r_discard};
    assign w_credit    = (w_occupancy < DEPTH_EXT);

    assign mem_req     = w_credit & ~redirect & ~reset;
    assign mem_addr    = r_fetch_pc;
    assign w_issue     = mem_req & mem_gnt;
    // A response with nothing outstanding cannot be matched to a PC, so it is ignored.
    assign w_rsp_taken = mem_rsp_valid & (r_outstanding != '0);
    assign w_push      = w_rsp_taken & ~redirect & (r_discard == '0);
    assign w_pop       = instr_valid & instr_ready & ~redirect;

    assign instr_valid = (w_count != '0);
    assign instr       = w_head[ENTRY_W-1:ADDR_W];
    assign instr_pc    = w_head[ADDR_W-1:0];
    assign pc_plus     = instr_pc + STEP;

    fetch_queue #(
        .DATA_W     (ENTRY_W),
        .DEPTH      (DEPTH),
        .RESET_DATA (RST_ENTRY)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (w_push),
        .push_data ({mem_rsp_data, r_rsp_pc}),
        .pop       (w_pop),
        .count     (w_count),
        .head      (w_head)
    );

    // Next-state for PCs and the outstanding/discard counters.
    always_comb begin
        w_fetch_pc_nxt    = r_fetch_pc;
        w_rsp_pc_nxt      = r_rsp_pc;
        w_outstanding_nxt = r_outstanding;
        w_discard_nxt     = r_discard;
        if (redirect) begin
            w_fetch_pc_nxt = redirect_pc;
            w_rsp_pc_nxt   = redirect_pc;
            // Everything still in flight after this cycle is stale; a response arriving now is dropped too.
            if (w_rsp_taken) begin
                w_outstanding_nxt = r_outstanding - CNT_ONE;
                w_discard_nxt     = r_outstanding - CNT_ONE;
            end else begin
                w_outstanding_nxt = r_outstanding;
                w_discard_nxt     = r_outstanding;
            end
        end else begin
            if (w_issue) begin
                w_fetch_pc_nxt = r_fetch_pc + STEP;
            end else begin
                w_fetch_pc_nxt = r_fetch_pc;
            end
            if (w_issue && !w_rsp_taken) begin
                w_outstanding_nxt = r_outstanding + CNT_ONE;
            end else if (!w_issue && w_rsp_taken) begin
                w_outstanding_nxt = r_outstanding - CNT_ONE;
            end else begin
                w_outstanding_nxt = r_outstanding;
            end
            if (w_rsp_taken && (r_discard != '0)) begin
                w_discard_nxt = r_discard - CNT_ONE;
            end else begin
                w_discard_nxt = r_discard;
            end
            if (w_push) begin
                w_rsp_pc_nxt = r_rsp_pc + STEP;
            end else begin
                w_rsp_pc_nxt = r_rsp_pc;
            end
        end
    end

    // State registers; reset overrides redirect and all handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RST_PC;
            r_rsp_pc      <= RST_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_rsp_pc      <= w_rsp_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
        end
    end

endmodule
